// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin owner of the single register-file write port.
// Supports locked bursts of up to MAX_LOCK beats; all outputs are registered.
module reg_write_arbiter #(
  parameter int DATA_W   = 12,
  parameter int N_REQ    = 3,
  parameter int MAX_LOCK = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [3*N_REQ-1:0]      tgt,
  input  logic [DATA_W*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [2:0]              selection_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    tgt_err
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [2:0] SEL_IDLE = 3'd7;

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q;
  logic              tgt_err_q, tgt_err_d;

  logic [N_REQ-1:0]  elig_s;
  logic              arb_s;
  logic              win_vld_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic [IDX_W:0]    pick_s;
  logic [2:0]        win_tgt_s;
  logic [DATA_W-1:0] win_data_s;

  // Returns {found, index} of the first set bit of r at or after p, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int c;
    res = {(IDX_W+1){1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = int'(p) + k;
      c = (c >= N_REQ) ? c - N_REQ : c;
      res = r[IDX_W'(c)] ? {1'b1, IDX_W'(c)} : res;
    end
    return res;
  endfunction

  // Burst continuation or round-robin arbitration, plus next-state bookkeeping.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    elig_s    = req;
    arb_s     = 1'b1;
    win_vld_s = 1'b0;
    win_idx_s = owner_q;
    pick_s    = {(IDX_W+1){1'b0}};
    if (state_q == ST_LOCKED) begin
      if (req[owner_q] && (!lock[owner_q] || (cnt_q < CNT_W'(MAX_LOCK)))) begin
        arb_s     = 1'b0;
        win_vld_s = 1'b1;
        win_idx_s = owner_q;
        if (lock[owner_q]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_ARB;
        end
      end else begin
        // Timeout excludes the owner so a waiting requester gets this edge.
        state_d = ST_ARB;
        if (req[owner_q]) begin
          elig_s[owner_q] = 1'b0;
        end else begin
          elig_s = req;
        end
      end
    end else begin
      elig_s = req;
    end
    if (arb_s) begin
      pick_s = rr_pick(elig_s, ptr_q);
      if (pick_s[IDX_W]) begin
        win_vld_s = 1'b1;
        win_idx_s = pick_s[IDX_W-1:0];
        ptr_d     = (pick_s[IDX_W-1:0] == IDX_W'(N_REQ - 1)) ?
                    {IDX_W{1'b0}} : pick_s[IDX_W-1:0] + IDX_W'(1);
        if (lock[pick_s[IDX_W-1:0]]) begin
          state_d = ST_LOCKED;
          owner_d = pick_s[IDX_W-1:0];
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_ARB;
        end
      end else begin
        win_vld_s = 1'b0;
      end
    end else begin
      pick_s = {(IDX_W+1){1'b0}};
    end
  end

  // Winner's payload mux and the next values of the registered outputs.
  always_comb begin
    win_tgt_s  = 3'd0;
    win_data_s = {DATA_W{1'b0}};
    gnt_d      = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_tgt_s  = win_tgt_s  | ({3{win_idx_s == IDX_W'(i)}} & tgt[3*i +: 3]);
      win_data_s = win_data_s | ({DATA_W{win_idx_s == IDX_W'(i)}} & wdata[DATA_W*i +: DATA_W]);
      gnt_d[i]   = win_vld_s && (win_idx_s == IDX_W'(i));
    end
    sel_d     = win_vld_s ? win_tgt_s : SEL_IDLE;
    wr_data_d = win_vld_s ? win_data_s : wr_data_q;
    tgt_err_d = win_vld_s && (win_tgt_s == SEL_IDLE);
  end

  // All state and outputs; reset drops any burst in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_ARB;
      ptr_q     <= {IDX_W{1'b0}};
      owner_q   <= {IDX_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      gnt_q     <= {N_REQ{1'b0}};
      sel_q     <= SEL_IDLE;
      wr_data_q <= {DATA_W{1'b0}};
      busy_q    <= 1'b0;
      tgt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      wr_data_q <= wr_data_d;
      busy_q    <= (state_d == ST_LOCKED);
      tgt_err_q <= tgt_err_d;
    end
  end

  assign gnt          = gnt_q;
  assign selection_en = sel_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign tgt_err      = tgt_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, single, contention, burst,
// timeout and bad-target vectors with hand-computed expectations.
module tb_reg_write_arbiter;
  logic        clk;
  logic        rstn;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [8:0]  tgt;
  logic [35:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  selection_en;
  logic [11:0] wr_data;
  logic        busy;
  logic        tgt_err;

  int n_vec;
  int n_err;

  reg_write_arbiter #(.DATA_W(12), .N_REQ(3), .MAX_LOCK(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock), .tgt(tgt), .wdata(wdata),
    .gnt(gnt), .selection_en(selection_en), .wr_data(wr_data), .busy(busy),
    .tgt_err(tgt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] eg, input logic [2:0] es,
                          input logic eb);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".sel"}, 32'(selection_en), 32'(es));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    req   = 3'b000;
    lock  = 3'b000;
    tgt   = 9'd0;
    wdata = 36'd0;
    #12;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.sel", 32'(selection_en), 32'd7);
    chk("rst.wr", 32'(wr_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(tgt_err), 32'd0);
    rstn = 1'b1;
    tick();

    // Single requester 1, held for two edges, then idle.
    req = 3'b010; tgt[5:3] = 3'd3; wdata[23:12] = 12'h0A5;
    tick();
    chk_beat("single1", 3'b010, 3'd3, 1'b0);
    chk("single1.wr", 32'(wr_data), 32'h0A5);
    tick();
    chk("single2.gnt", 32'(gnt), 32'(3'b010));
    req = 3'b000;
    tick();
    chk_beat("idle", 3'b000, 3'd7, 1'b0);
    chk("idle.wr_hold", 32'(wr_data), 32'h0A5);
    req = 3'b010;
    tick();
    chk("pre_rst.gnt", 32'(gnt), 32'(3'b010));

    // Mid-run asynchronous reset, observed without a clock edge.
    req = 3'b000;
    rstn = 1'b0;
    #2;
    chk("midrst.gnt", 32'(gnt), 32'd0);
    chk("midrst.sel", 32'(selection_en), 32'd7);
    chk("midrst.wr", 32'(wr_data), 32'd0);
    rstn = 1'b1;

    // Contention, no lock: pointer restarts at 0.
    req = 3'b111;
    tgt = {3'd5, 3'd4, 3'd2};
    wdata = {12'h333, 12'h222, 12'h111};
    tick();
    chk_beat("cont1", 3'b001, 3'd2, 1'b0);
    chk("cont1.wr", 32'(wr_data), 32'h111);
    tick();
    chk_beat("cont2", 3'b010, 3'd4, 1'b0);
    chk("cont2.wr", 32'(wr_data), 32'h222);
    tick();
    chk_beat("cont3", 3'b100, 3'd5, 1'b0);
    chk("cont3.wr", 32'(wr_data), 32'h333);
    tick();
    chk_beat("cont4", 3'b001, 3'd2, 1'b0);

    // Burst by requester 2 while requester 0 waits; pointer is now 1.
    req = 3'b101; lock = 3'b100;
    for (int b = 0; b < 3; b++) begin
      tick();
      chk_beat($sformatf("burst%0d", b + 1), 3'b100, 3'd5, 1'b1);
    end
    lock = 3'b000;
    tick();
    chk_beat("burst4", 3'b100, 3'd5, 1'b0);
    req = 3'b001;
    tick();
    chk_beat("after_burst", 3'b001, 3'd2, 1'b0);

    // Timeout: pointer is 1, so requester 1 wins once, then 0 locks 8 beats.
    req = 3'b011; lock = 3'b001;
    tick();
    chk_beat("to_pre", 3'b010, 3'd4, 1'b0);
    for (int b = 0; b < 8; b++) begin
      tick();
      chk_beat($sformatf("to_beat%0d", b + 1), 3'b001, 3'd2, 1'b1);
    end
    tick();
    chk_beat("to_release", 3'b010, 3'd4, 1'b0);
    req = 3'b000; lock = 3'b000;
    tick();
    chk_beat("to_idle", 3'b000, 3'd7, 1'b0);

    // Bad target code from requester 0.
    req = 3'b001; tgt[2:0] = 3'd7; wdata[11:0] = 12'h7FF;
    tick();
    chk_beat("badtgt", 3'b001, 3'd7, 1'b0);
    chk("badtgt.err", 32'(tgt_err), 32'd1);
    req = 3'b000;
    tick();
    chk("badtgt_next.err", 32'(tgt_err), 32'd0);
    chk("badtgt_next.gnt", 32'(gnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
